// File: rtl/scan_chain_spi_ctrl.sv
// Scan-chain SPI controller: shifts one word into a selected analog scan chain using
// non-overlapping two-phase shift clocks, then strobes that chain's latch. Optional macro: SCAN_READBACK_EN.
module scan_chain_spi_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int CLK_DIV    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [CH_W-1:0]       CH_SEL,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  LSB_FIRST,
    input  logic                  SPI_SI,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  SCLK1,
    output logic                  SCLK2,
    output logic                  SPI_SO,
    output logic [NUM_CH-1:0]     LAT,
    output logic [DATA_WIDTH-1:0] RDATA
);

    // state    | meaning
    // st_idle  | waiting for START; bad CH_SEL gives a one-cycle ERR
    // st_setup | word captured, first bit on SPI_SO
    // st_ph1   | SCLK1 high for CLK_DIV cycles
    // st_gap1  | both shift clocks low
    // st_ph2   | SCLK2 high for CLK_DIV cycles, SPI_SI sampled on its last edge
    // st_gap2  | both low, next bit on SPI_SO
    // st_latch | LAT[ch] high for CLK_DIV cycles
    // st_done  | strobe released; DONE pulse issued on exit
    typedef enum logic [2:0] {
        st_idle, st_setup, st_ph1, st_gap1, st_ph2, st_gap2, st_latch, st_done
    } state_t;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [CH_W-1:0]       ch_q;
    logic                  lsb_q;
    logic                  next_bit;
    logic                  ch_ok;
    logic [NUM_CH-1:0]     lat_onehot;
    logic [DATA_WIDTH-1:0] rx_word;

    assign ch_ok    = 32'(CH_SEL) < NUM_CH;
    assign tx_next  = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
    assign next_bit = lsb_q ? tx_next[0] : tx_next[DATA_WIDTH-1];

    always_comb begin
        lat_onehot = '0;
        for (int i = 0; i < NUM_CH; i++)
            lat_onehot[i] = (32'(ch_q) == i);
    end

`ifdef SCAN_READBACK_EN
    logic [DATA_WIDTH-1:0] rx_sr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rx_sr <= '0;
        else if (state == st_ph2 && cnt == '0)
            rx_sr <= lsb_q ? {SPI_SI, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], SPI_SI};
    end

    assign rx_word = rx_sr;
`else
    logic unused_si;
    assign unused_si = SPI_SI;
    assign rx_word   = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= st_idle;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            ch_q    <= '0;
            lsb_q   <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            SCLK1   <= 1'b0;
            SCLK2   <= 1'b0;
            SPI_SO  <= 1'b0;
            LAT     <= '0;
            RDATA   <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                st_idle: begin
                    if (START) begin
                        if (ch_ok) begin
                            state   <= st_setup;
                            BUSY    <= 1'b1;
                            tx_sr   <= DATA_IN;
                            ch_q    <= CH_SEL;
                            lsb_q   <= LSB_FIRST;
                            bit_cnt <= '0;
                            SPI_SO  <= LSB_FIRST ? DATA_IN[0] : DATA_IN[DATA_WIDTH-1];
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                st_setup: begin
                    state <= st_ph1;
                    SCLK1 <= 1'b1;
                    cnt   <= CNT_LOAD;
                end
                st_ph1: begin
                    if (cnt == '0) begin
                        state <= st_gap1;
                        SCLK1 <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                st_gap1: begin
                    state <= st_ph2;
                    SCLK2 <= 1'b1;
                    cnt   <= CNT_LOAD;
                end
                st_ph2: begin
                    if (cnt == '0) begin
                        state  <= st_gap2;
                        SCLK2  <= 1'b0;
                        tx_sr  <= tx_next;
                        SPI_SO <= next_bit;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                st_gap2: begin
                    if (bit_cnt == BIT_LAST) begin
                        state <= st_latch;
                        LAT   <= lat_onehot;
                        cnt   <= CNT_LOAD;
                    end else begin
                        state   <= st_ph1;
                        SCLK1   <= 1'b1;
                        cnt     <= CNT_LOAD;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                st_latch: begin
                    if (cnt == '0) begin
                        state <= st_done;
                        LAT   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // One quiet cycle after the strobe falls so the chain data is held past the latch edge.
                st_done: begin
                    state  <= st_idle;
                    DONE   <= 1'b1;
                    BUSY   <= 1'b0;
                    SPI_SO <= 1'b0;
                    RDATA  <= rx_word;
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule
